bar_level_tracker: RTL

//  Producer of the ten 24-bit bar amplitudes (x0..x9) read by the colour mapper.

---
 rtl/bar_level_tracker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bar_level_tracker.sv
`default_nettype none
// ============================================================================
// Module      : bar_level_tracker
// Description : Per-band peak accumulator with per-frame attack/decay commit and
//               atomic publication of ten bar levels on each vertical-sync edge.
// Revision    : 1.0 - initial release
// ============================================================================
module bar_level_tracker #(
    parameter int MAG_W       = 24,
    parameter int DECAY_SHIFT = 3,
    parameter int VS_ACT_LOW  = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             VS,
    input  logic             Freeze,
    input  logic             band_valid,
    output logic             band_ready,
    input  logic [3:0]       band_idx,
    input  logic [MAG_W-1:0] band_mag,
    output logic [MAG_W-1:0] x0,
    output logic [MAG_W-1:0] x1,
    output logic [MAG_W-1:0] x2,
    output logic [MAG_W-1:0] x3,
    output logic [MAG_W-1:0] x4,
    output logic [MAG_W-1:0] x5,
    output logic [MAG_W-1:0] x6,
    output logic [MAG_W-1:0] x7,
    output logic [MAG_W-1:0] x8,
    output logic [MAG_W-1:0] x9,
    output logic             frame_done,
    output logic             bad_idx
);

    localparam int               c_NBANDS      = 10;
    localparam logic             c_VS_IDLE     = (VS_ACT_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [MAG_W-1:0] c_DECAY_FLOOR = MAG_W'(1) << DECAY_SHIFT;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_COMMIT  = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       b_q, b_d;
    logic             vs_q;
    logic             ready_q, ready_d;
    logic             frame_done_q, frame_done_d;
    logic             bad_idx_q, bad_idx_d;
    logic [MAG_W-1:0] acc_q [c_NBANDS];
    logic [MAG_W-1:0] acc_d [c_NBANDS];
    logic [MAG_W-1:0] lvl_q [c_NBANDS];
    logic [MAG_W-1:0] lvl_d [c_NBANDS];
    logic [MAG_W-1:0] x_q   [c_NBANDS];
    logic [MAG_W-1:0] x_d   [c_NBANDS];

    logic w_edge;
    logic w_xfer;

    assign w_edge = (VS_ACT_LOW != 0) ? (!VS && vs_q) : (VS && !vs_q);
    assign w_xfer = band_valid && ready_q;

    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        acc_d        = acc_q;
        lvl_d        = lvl_q;
        x_d          = x_q;
        frame_done_d = 1'b0;
        bad_idx_d    = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                if (w_xfer) begin
                    if (band_idx > 4'd9) begin
                        bad_idx_d = 1'b1;
                    end else begin
                        for (int i = 0; i < c_NBANDS; i++) begin
                            if (band_idx == 4'(i) && band_mag > acc_q[i]) begin
                                acc_d[i] = band_mag;
                            end
                        end
                    end
                end
                if (w_edge) begin
                    state_d = ST_COMMIT;
                    b_d     = 4'd0;
                end
            end
            ST_COMMIT: begin
                for (int i = 0; i < c_NBANDS; i++) begin
                    if (b_q == 4'(i)) begin
                        // Small levels would never decay (shift yields 0), so snap them to zero.
                        if (acc_q[i] >= lvl_q[i]) begin
                            lvl_d[i] = acc_q[i];
                        end else if (lvl_q[i] < c_DECAY_FLOOR) begin
                            lvl_d[i] = '0;
                        end else begin
                            lvl_d[i] = lvl_q[i] - (lvl_q[i] >> DECAY_SHIFT);
                        end
                        acc_d[i] = '0;
                    end
                end
                if (b_q == 4'd9) begin
                    state_d = ST_PUBLISH;
                end else begin
                    b_d = b_q + 4'd1;
                end
            end
            ST_PUBLISH: begin
                if (!Freeze) begin
                    x_d          = lvl_q;
                    frame_done_d = 1'b1;
                end
                state_d = ST_ACCUM;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        ready_d = (state_d == ST_ACCUM);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_ACCUM;
            b_q          <= 4'd0;
            vs_q         <= c_VS_IDLE;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            bad_idx_q    <= 1'b0;
            for (int i = 0; i < c_NBANDS; i++) begin
                acc_q[i] <= '0;
                lvl_q[i] <= '0;
                x_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            b_q          <= b_d;
            vs_q         <= VS;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            bad_idx_q    <= bad_idx_d;
            acc_q        <= acc_d;
            lvl_q        <= lvl_d;
            x_q          <= x_d;
        end
    end

    assign band_ready = ready_q;
    assign frame_done = frame_done_q;
    assign bad_idx    = bad_idx_q;
    assign x0 = x_q[0];
    assign x1 = x_q[1];
    assign x2 = x_q[2];
    assign x3 = x_q[3];
    assign x4 = x_q[4];
    assign x5 = x_q[5];
    assign x6 = x_q[6];
    assign x7 = x_q[7];
    assign x8 = x_q[8];
    assign x9 = x_q[9];

endmodule
`default_nettype wire
